// File: rtl/ram_stream_reader.sv
// Burst reader: streams `length` words from a synchronous-read RAM, starting at start_addr,
// through a 2-entry skid FIFO onto a valid/ready stream.
module ram_stream_reader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic [AW:0]      length,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    ram_addr,
  output logic             ram_wr_en,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic [AW:0]     issue_left_q;
  logic [AW:0]     beats_left_q;
  logic            inflight_q;
  logic [1:0]      count_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic            busy_q;
  logic            done_q;

  logic            pop;
  logic            issue;
  logic [2:0]      occ;
  logic [AW-1:0]   addr_next;

  assign ram_addr  = addr_q;
  assign ram_wr_en = 1'b0;
  assign m_data    = head_q;
  assign m_valid   = (count_q != 2'd0);
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    pop = m_valid && m_ready;
    // Occupancy after this cycle's pop; keeps in-flight plus buffered words at most 2.
    occ = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue = (state_q == StRead) && (occ < 3'd2);
    if (addr_q == AW'(DEPTH - 1)) begin
      addr_next = '0;
    end else begin
      addr_next = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      issue_left_q <= '0;
      beats_left_q <= '0;
      inflight_q   <= 1'b0;
      count_q      <= 2'd0;
      head_q       <= '0;
      tail_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      inflight_q <= issue;

      // Capture the word read last cycle; head_q is always the word on m_data.
      unique case ({inflight_q, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_q <= ram_dout;
          end else begin
            tail_q <= ram_dout;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            head_q <= tail_q;
          end
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= ram_dout;
          end else begin
            head_q <= tail_q;
            tail_q <= ram_dout;
          end
        end
        default: ;
      endcase

      if (issue) begin
        addr_q       <= addr_next;
        issue_left_q <= issue_left_q - 1'b1;
      end
      if (pop) begin
        beats_left_q <= beats_left_q - 1'b1;
      end

      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy_q <= 1'b1;
            if (length == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q      <= StRead;
              addr_q       <= start_addr;
              issue_left_q <= length;
              beats_left_q <= length;
            end
          end
        end
        StRead: begin
          if (issue && (issue_left_q == (AW+1)'(1))) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && (beats_left_q == (AW+1)'(1))) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
